// File: rtl/cpu_mem_responder.sv
// Memory-side responder: arbitrates fetch and LSQ requests onto one downstream pmem port.
// Optional macro ARB_RR_EN selects round-robin tie-breaking instead of fixed LSQ priority.
module cpu_mem_responder #(
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [width/8-1:0]   i_mem_byte_enable,
  input  logic [width-1:0]     i_mem_address,
  input  logic [width-1:0]     i_mem_wdata,
  output logic                 i_mem_resp,
  output logic [width-1:0]     i_mem_rdata,
  input  logic                 lsq_mem_read,
  input  logic                 lsq_mem_write,
  input  logic [width/8-1:0]   lsq_mem_byte_enable,
  input  logic [width-1:0]     lsq_mem_address,
  input  logic [width-1:0]     lsq_mem_wdata,
  output logic                 lsq_mem_resp,
  output logic [width-1:0]     lsq_mem_rdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [width/8-1:0]   pmem_byte_enable,
  output logic [width-1:0]     pmem_address,
  output logic [width-1:0]     pmem_wdata,
  input  logic                 pmem_resp,
  input  logic [width-1:0]     pmem_rdata
);

  localparam int BeW = width / 8;

`ifdef ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {GRANT_LSQ, GRANT_FETCH} grant_e;

  state_e           state_q;
  grant_e           grant_q;
  grant_e           last_grant_q;
  grant_e           grant_d;
  logic             pmem_read_q;
  logic             pmem_write_q;
  logic [BeW-1:0]   pmem_be_q;
  logic [width-1:0] pmem_addr_q;
  logic [width-1:0] pmem_wdata_q;
  logic             i_resp_q;
  logic             lsq_resp_q;
  logic [width-1:0] i_rdata_q;
  logic [width-1:0] lsq_rdata_q;
  logic             fetch_req;
  logic             lsq_req;

  assign fetch_req = i_mem_read | i_mem_write;
  assign lsq_req   = lsq_mem_read | lsq_mem_write;

  // Ties go to the LSQ unless round-robin is built in, then the port opposite the last winner wins.
  assign grant_d = (fetch_req && (!lsq_req || (RrEn && (last_grant_q == GRANT_LSQ))))
                   ? GRANT_FETCH : GRANT_LSQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_LSQ;
      last_grant_q <= GRANT_LSQ;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_be_q    <= '0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
      i_resp_q     <= 1'b0;
      lsq_resp_q   <= 1'b0;
      i_rdata_q    <= '0;
      lsq_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_req || lsq_req) begin
            state_q      <= BUSY;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            // A simultaneous read and write is treated as a write.
            if (grant_d == GRANT_FETCH) begin
              pmem_addr_q  <= i_mem_address;
              pmem_wdata_q <= i_mem_wdata;
              pmem_be_q    <= i_mem_byte_enable;
              pmem_write_q <= i_mem_write;
              pmem_read_q  <= ~i_mem_write;
            end else begin
              pmem_addr_q  <= lsq_mem_address;
              pmem_wdata_q <= lsq_mem_wdata;
              pmem_be_q    <= lsq_mem_byte_enable;
              pmem_write_q <= lsq_mem_write;
              pmem_read_q  <= ~lsq_mem_write;
            end
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            state_q      <= RESP;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_be_q    <= '0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
            if (grant_q == GRANT_FETCH) begin
              i_resp_q  <= 1'b1;
              i_rdata_q <= pmem_write_q ? '0 : pmem_rdata;
            end else begin
              lsq_resp_q  <= 1'b1;
              lsq_rdata_q <= pmem_write_q ? '0 : pmem_rdata;
            end
          end
        end
        RESP: begin
          state_q     <= IDLE;
          i_resp_q    <= 1'b0;
          lsq_resp_q  <= 1'b0;
          i_rdata_q   <= '0;
          lsq_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pmem_read        = pmem_read_q;
  assign pmem_write       = pmem_write_q;
  assign pmem_byte_enable = pmem_be_q;
  assign pmem_address     = pmem_addr_q;
  assign pmem_wdata       = pmem_wdata_q;
  assign i_mem_resp       = i_resp_q;
  assign i_mem_rdata      = i_rdata_q;
  assign lsq_mem_resp     = lsq_resp_q;
  assign lsq_mem_rdata    = lsq_rdata_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus randomized traffic
// compared each cycle against a transaction-timeline model of the responder.
module tb_cpu_mem_responder;

  localparam int W = 32;

`ifdef ARB_RR_EN
  localparam bit rrEn = 1'b1;
`else
  localparam bit rrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mem_read, i_mem_write, i_mem_resp;
  logic [3:0]    i_mem_byte_enable;
  logic [W-1:0]  i_mem_address, i_mem_wdata, i_mem_rdata;
  logic          lsq_mem_read, lsq_mem_write, lsq_mem_resp;
  logic [3:0]    lsq_mem_byte_enable;
  logic [W-1:0]  lsq_mem_address, lsq_mem_wdata, lsq_mem_rdata;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [3:0]    pmem_byte_enable;
  logic [W-1:0]  pmem_address, pmem_wdata, pmem_rdata;

  always #5 clk = ~clk;

  cpu_mem_responder #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_byte_enable(i_mem_byte_enable), .i_mem_address(i_mem_address),
    .i_mem_wdata(i_mem_wdata), .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .lsq_mem_read(lsq_mem_read), .lsq_mem_write(lsq_mem_write),
    .lsq_mem_byte_enable(lsq_mem_byte_enable), .lsq_mem_address(lsq_mem_address),
    .lsq_mem_wdata(lsq_mem_wdata), .lsq_mem_resp(lsq_mem_resp), .lsq_mem_rdata(lsq_mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_byte_enable(pmem_byte_enable),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  int assertCount = 0;
  int failCount = 0;
  int cyc = 0;
  int fetchResps = 0;
  int lsqResps = 0;

  // Model: one transaction described by when it was accepted and when pmem finished it.
  bit         txnValid = 1'b0;
  bit         txnFetch, txnWrite;
  logic [31:0] txnAddr, txnWdata, txnRdata;
  logic [3:0] txnBe;
  int         acceptCyc = 0;
  int         doneCyc = -1;
  bit         lastFetch = 1'b0;

  // Random-phase initiator and downstream state
  bit fPend = 0, lPend = 0, fJustResp = 0, lJustResp = 0;
  int fWait = 0, lWait = 0, maxFWait = 0, maxLWait = 0, dWait = -1;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
    end
  endtask

  function automatic bit modelActive();
    return txnValid && (cyc > acceptCyc) && (doneCyc < 0 || cyc <= doneCyc);
  endfunction

  function automatic bit modelResp();
    return txnValid && (doneCyc >= 0) && (cyc == doneCyc + 1);
  endfunction

  task automatic resetModel();
    txnValid = 1'b0;
    lastFetch = 1'b0;
    doneCyc = -1;
  endtask

  task automatic checkOutput();
    bit act, rsp;
    act = modelActive();
    rsp = modelResp();
    checkValue("pmem_read", 32'(pmem_read), 32'(act && !txnWrite));
    checkValue("pmem_write", 32'(pmem_write), 32'(act && txnWrite));
    if (act) begin
      checkValue("pmem_address", pmem_address, txnAddr);
      checkValue("pmem_byte_enable", 32'(pmem_byte_enable), 32'(txnBe));
      checkValue("pmem_wdata", pmem_wdata, txnWdata);
    end
    checkValue("i_mem_resp", 32'(i_mem_resp), 32'(rsp && txnFetch));
    checkValue("i_mem_rdata", i_mem_rdata, (rsp && txnFetch) ? txnRdata : 32'h0);
    checkValue("lsq_mem_resp", 32'(lsq_mem_resp), 32'(rsp && !txnFetch));
    checkValue("lsq_mem_rdata", lsq_mem_rdata, (rsp && !txnFetch) ? txnRdata : 32'h0);
  endtask

  task automatic modelStep();
    bit act, free, fReq, lReq, pickFetch;
    if (!rst) begin
      resetModel();
      return;
    end
    act  = modelActive();
    free = !txnValid || (doneCyc >= 0 && cyc >= doneCyc + 2);
    if (act && pmem_resp && doneCyc < 0) begin
      doneCyc  = cyc;
      txnRdata = txnWrite ? 32'h0 : pmem_rdata;
    end else if (free) begin
      txnValid = 1'b0;
      fReq = i_mem_read | i_mem_write;
      lReq = lsq_mem_read | lsq_mem_write;
      if (fReq || lReq) begin
        pickFetch = fReq && (!lReq || (rrEn && !lastFetch));
        lastFetch = pickFetch;
        txnValid  = 1'b1;
        txnFetch  = pickFetch;
        acceptCyc = cyc;
        doneCyc   = -1;
        txnWrite  = pickFetch ? i_mem_write : lsq_mem_write;
        txnAddr   = pickFetch ? i_mem_address : lsq_mem_address;
        txnBe     = pickFetch ? i_mem_byte_enable : lsq_mem_byte_enable;
        txnWdata  = pickFetch ? i_mem_wdata : lsq_mem_wdata;
      end
    end
  endtask

  task automatic tick();
    if (!rst) resetModel();
    #1;
    checkOutput();
    if (i_mem_resp === 1'b1) fetchResps++;
    if (lsq_mem_resp === 1'b1) lsqResps++;
    modelStep();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idleInputs();
    i_mem_read = 0; i_mem_write = 0;
    lsq_mem_read = 0; lsq_mem_write = 0;
    pmem_resp = 0;
  endtask

  task automatic settle();
    idleInputs();
    repeat (3) tick();
  endtask

  task automatic applyStimulus(input int k);
    int op;
    rst = (k == 1500) ? 1'b0 : 1'b1;
    if (fJustResp) begin fPend = 0; fJustResp = 0; end
    if (lJustResp) begin lPend = 0; lJustResp = 0; end
    if (!fPend && $urandom_range(0, 99) < 45) begin
      fPend = 1; fWait = 0;
      op = int'($urandom_range(0, 9));
      i_mem_read = (op != 8); i_mem_write = (op >= 8);
      i_mem_address = $urandom; i_mem_wdata = $urandom; i_mem_byte_enable = 4'($urandom);
    end
    if (!fPend) begin
      i_mem_read = 0; i_mem_write = 0;
      i_mem_address = $urandom; i_mem_wdata = $urandom;
    end else begin
      fWait++;
      if (fWait > maxFWait) maxFWait = fWait;
      if (i_mem_resp) fJustResp = 1;
    end
    if (!lPend && $urandom_range(0, 99) < 45) begin
      lPend = 1; lWait = 0;
      op = int'($urandom_range(0, 9));
      lsq_mem_read = (op < 6 || op == 9); lsq_mem_write = (op >= 6);
      lsq_mem_address = $urandom; lsq_mem_wdata = $urandom; lsq_mem_byte_enable = 4'($urandom);
    end
    if (!lPend) begin
      lsq_mem_read = 0; lsq_mem_write = 0;
      lsq_mem_address = $urandom; lsq_mem_wdata = $urandom;
    end else begin
      lWait++;
      if (lWait > maxLWait) maxLWait = lWait;
      if (lsq_mem_resp) lJustResp = 1;
    end
    // Downstream memory answers after 0-3 wait cycles and occasionally pulses resp while idle.
    pmem_rdata = $urandom;
    if (pmem_read || pmem_write) begin
      if (dWait < 0) dWait = int'($urandom_range(0, 3));
      if (dWait == 0) begin pmem_resp = 1; dWait = -1; end
      else begin pmem_resp = 0; dWait--; end
    end else begin
      pmem_resp = ($urandom_range(0, 9) == 0);
      dWait = -1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit [3:0] order;
    int n, startResps;
    bit got;

    rst = 1'b1;
    idleInputs();
    i_mem_address = 0; i_mem_wdata = 0; i_mem_byte_enable = 4'hF;
    lsq_mem_address = 0; lsq_mem_wdata = 0; lsq_mem_byte_enable = 4'hF;
    pmem_rdata = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset checks");
    checkValue("reset pmem_read", 32'(pmem_read), 0);
    checkValue("reset pmem_write", 32'(pmem_write), 0);
    checkValue("reset pmem_address", pmem_address, 0);
    checkValue("reset i_mem_resp", 32'(i_mem_resp), 0);
    checkValue("reset lsq_mem_resp", 32'(lsq_mem_resp), 0);
    tick();
    rst = 1'b1;
    settle();

    $display("[TB] fetch read with two wait cycles");
    i_mem_read = 1; i_mem_address = 32'h60; i_mem_byte_enable = 4'hF; tick();
    checkValue("t1 pmem_read c1", 32'(pmem_read), 1);
    checkValue("t1 pmem_address c1", pmem_address, 32'h60); tick();
    checkValue("t1 pmem_read c2", 32'(pmem_read), 1); tick();
    checkValue("t1 pmem_read c3", 32'(pmem_read), 1);
    pmem_resp = 1; pmem_rdata = 32'h0051_3023; tick();
    pmem_resp = 0; pmem_rdata = 32'hFFFF_0000;
    checkValue("t1 i_mem_resp c4", 32'(i_mem_resp), 1);
    checkValue("t1 i_mem_rdata c4", i_mem_rdata, 32'h0051_3023);
    checkValue("t1 lsq_mem_resp c4", 32'(lsq_mem_resp), 0); tick();
    i_mem_read = 0;
    checkValue("t1 i_mem_resp c5", 32'(i_mem_resp), 0);
    settle();

    $display("[TB] LSQ write with zero-wait memory");
    lsq_mem_write = 1; lsq_mem_address = 32'h100; lsq_mem_byte_enable = 4'b0011;
    lsq_mem_wdata = 32'hDEAD_BEEF; tick();
    checkValue("t2 pmem_write c1", 32'(pmem_write), 1);
    checkValue("t2 pmem_byte_enable c1", 32'(pmem_byte_enable), 32'h3);
    checkValue("t2 pmem_wdata c1", pmem_wdata, 32'hDEAD_BEEF);
    pmem_resp = 1; pmem_rdata = 32'h1234_5678; tick();
    pmem_resp = 0;
    checkValue("t2 lsq_mem_resp c2", 32'(lsq_mem_resp), 1);
    checkValue("t2 lsq_mem_rdata c2", lsq_mem_rdata, 0); tick();
    settle();

    $display("[TB] fetch re-request after resp");
    startResps = fetchResps;
    i_mem_read = 1; i_mem_address = 32'h60; tick();
    pmem_resp = 1; pmem_rdata = 32'hA5A5_0001; tick();
    pmem_resp = 0; tick();
    i_mem_address = 32'h64; tick();
    checkValue("t4 second pmem_read", 32'(pmem_read), 1);
    checkValue("t4 second pmem_address", pmem_address, 32'h64);
    pmem_resp = 1; pmem_rdata = 32'hA5A5_0002; tick();
    pmem_resp = 0;
    checkValue("t4 second i_mem_rdata", i_mem_rdata, 32'hA5A5_0002); tick();
    i_mem_read = 0;
    settle();
    checkValue("t4 i_mem_resp pulses", 32'(fetchResps - startResps), 2);

    $display("[TB] spurious pmem_resp while idle");
    startResps = fetchResps + lsqResps;
    pmem_resp = 1; pmem_rdata = 32'h7777_7777; tick();
    pmem_resp = 0; tick(); tick();
    checkValue("t6 no upstream resp", 32'(fetchResps + lsqResps - startResps), 0);

    $display("[TB] reset during BUSY");
    i_mem_read = 1; i_mem_address = 32'h200; tick();
    checkValue("t5 pmem_read busy", 32'(pmem_read), 1); tick();
    rst = 1'b0; #1;
    checkValue("t5 pmem_read in reset", 32'(pmem_read), 0);
    checkValue("t5 pmem_address in reset", pmem_address, 0);
    pmem_resp = 1; tick();
    pmem_resp = 0; rst = 1'b1; i_mem_read = 0; tick();
    checkValue("t5 no i_mem_resp after reset", 32'(i_mem_resp), 0); tick();
    lsq_mem_read = 1; lsq_mem_address = 32'h300; lsq_mem_byte_enable = 4'hF; tick();
    checkValue("t5 post-reset pmem_address", pmem_address, 32'h300);
    pmem_resp = 1; pmem_rdata = 32'h0BAD_F00D; tick();
    pmem_resp = 0;
    checkValue("t5 post-reset lsq_mem_rdata", lsq_mem_rdata, 32'h0BAD_F00D); tick();
    settle();

    $display("[TB] both ports reading continuously");
    order = 4'b0; n = 0;
    i_mem_read = 1; i_mem_address = 32'h1000;
    lsq_mem_read = 1; lsq_mem_address = 32'h2000;
    for (int k = 0; k < 80 && n < 4; k++) begin
      pmem_resp = pmem_read | pmem_write; pmem_rdata = $urandom;
      if (i_mem_resp && n < 4) begin order[n] = 1'b1; n++; i_mem_address += 4; end
      if (lsq_mem_resp && n < 4) begin order[n] = 1'b0; n++; lsq_mem_address += 4; end
      tick();
    end
    checkValue("t3 transactions completed", 32'(n), 4);
    checkValue("t3 grant order", 32'(order), rrEn ? 32'h5 : 32'h0);
    lsq_mem_read = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      pmem_resp = pmem_read | pmem_write; pmem_rdata = $urandom;
      if (i_mem_resp) got = 1;
      tick();
    end
    checkValue("t3 fetch served after LSQ drops", 32'(got), 1);
    settle();

    $display("[TB] randomized traffic");
    startResps = fetchResps + lsqResps;
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(k);
      tick();
    end
    rst = 1'b1;
    settle();
    checkValue("random fetch wait bound", 32'(maxFWait < 300), 1);
    checkValue("random lsq wait bound", 32'(maxLWait < 300), 1);
    checkValue("random traffic completed", 32'((fetchResps + lsqResps - startResps) > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
